// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, one imem read per cycle, prefetch queue to decode.
// Latency: 2 cycles from issue (or reset release) to out_valid; redirect to out_valid is 3 cycles.
// Backpressure: out_ready low fills the queue, then issue stops once count + inflight reaches depth.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset (beats redirect)
//   fetch_en            allow new reads; an in-flight read always completes
//   redirect_valid/_pc  one-cycle pulse: load new PC, flush queue, drop in-flight word
//   imem_rd_en/addr     read strobe and address (address = fetch PC at all times)
//   imem_data           read data, valid the cycle after imem_rd_en
//   out_valid/ready     valid/ready handshake to decode
//   out_instr/out_pc    head entry (zero when empty)
//   queue_count         entries currently buffered

// Small generic synchronous FIFO with flush; head is shown combinationally.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the producer must never push when full.
module if_fetch_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign do_push  = push_vld;
  assign do_pop   = pop_rdy & head_vld;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// Instruction-fetch stage top.
// Latency: issue at cycle n, word enters queue at end of n+1, visible at n+2.
// Backpressure: issue is credit-limited by count + inflight against QUEUE_DEPTH.
module if_fetch_queue #(
  parameter int          ADDR_WIDTH  = 20,
  parameter int          INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = 'h20,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          imem_rd_en,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic [INSTR_WIDTH-1:0]        imem_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTR_WIDTH-1:0]        out_instr,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int                  CW     = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [CW:0]         DEPTH_LIM = (CW+1)'(QUEUE_DEPTH);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  issue;
  logic [CW:0]           occupancy;

  entry_t                push_ent;
  entry_t                head_ent;
  logic                  push_vld;
  logic                  pop_rdy;
  logic                  head_vld;
  logic [CW-1:0]         count;

  // A slot is reserved for the in-flight word, so a return can never find the
  // queue full. A pop this cycle does not free a credit until the next cycle.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue      = rst & fetch_en & ~redirect_valid & (occupancy < DEPTH_LIM);
  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc;

  // The word returning on a redirect cycle belongs to the old stream.
  assign push_vld       = inflight & ~redirect_valid;
  assign push_ent.instr = imem_data;
  assign push_ent.pc    = inflight_pc;
  assign pop_rdy        = out_ready & ~redirect_valid;

  if_fetch_queue_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push_vld (push_vld),
    .push_dat (push_ent),
    .pop_rdy  (pop_rdy),
    .head_vld (head_vld),
    .head_dat (head_ent),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RST_PC;
      inflight_pc <= RST_PC;
      inflight    <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      inflight    <= 1'b0;
    end else if (issue) begin
      inflight_pc <= fetch_pc;
      inflight    <= 1'b1;
      fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
    end else begin
      inflight    <= 1'b0;
    end
  end

  assign out_valid   = head_vld;
  assign out_instr   = head_vld ? head_ent.instr : '0;
  assign out_pc      = head_vld ? head_ent.pc    : '0;
  assign queue_count = count;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage: owns the program counter, issues one synchronous read per cycle to the instruction memory, and buffers returned words with their PCs in a prefetch queue drained by decode through a valid/ready handshake. Generalises the single-register PC circuit with configurable address/instruction width and reset vector, a fetch-enable, control-flow redirect with flush, and backpressure. Sits between the instruction memory and the decode stage.

## Interface
- ADDR_WIDTH, 20, width of PC and memory address
- INSTR_WIDTH, 16, width of one instruction word
- RESET_PC, 'h20, PC loaded at reset (low ADDR_WIDTH bits used)
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, >= 2

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- fetch_en  in  1  1 = new reads may issue; 0 = no new issues, in-flight read still completes
- redirect_valid  in  1  load new PC and flush, one-cycle pulse
- redirect_pc  in  ADDR_WIDTH  target PC for redirect
- imem_rd_en  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_WIDTH  read address (= current fetch PC)
- imem_data  in  INSTR_WIDTH  read data, valid the cycle after imem_rd_en
- out_valid  out  1  queue head holds an instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  INSTR_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  PC of head instruction
- queue_count  out  $clog2(QUEUE_DEPTH)+1  entries currently in queue

## Operation
- State: fetch_pc, inflight flag + inflight_pc, circular queue (rd/wr pointers, count) of {instr, pc}.
- imem_addr = fetch_pc combinationally at all times.
- Issue: imem_rd_en = fetch_en & ~redirect_valid & (count + inflight < QUEUE_DEPTH). Popping in the same cycle grants no credit.
- On issue: inflight_pc <= fetch_pc, inflight <= 1, fetch_pc <= fetch_pc + 1, wrapping modulo 2^ADDR_WIDTH (all-ones -> 0). Without issue, inflight <= 0.
- Return: when inflight = 1 at a clock edge, {imem_data, inflight_pc} is written at wr pointer. Issue rule guarantees the queue is never full at return; no overflow path exists.
- Pop: out_valid & out_ready advances rd pointer. Push and pop in one cycle leave count unchanged.
- out_valid = (count != 0); out_instr/out_pc show the head entry; both forced to 0 when empty.
- Redirect (redirect_valid = 1): fetch_pc <= redirect_pc; queue emptied (pointers and count to 0); inflight data returning this cycle discarded; inflight <= 0; concurrent pop ignored; no issue this cycle.
- fetch_en = 0: fetch_pc holds; queue still drains; redirect still honoured.
- Reset (rst = 0 at edge, overrides everything including redirect): fetch_pc = RESET_PC, inflight = 0, queue empty.

## Timing
- Outputs during/after reset: imem_rd_en = 0 while rst = 0, imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, queue_count = 0.
- Memory latency: exactly 1 cycle, read registered inside memory.
- Reset release (first cycle with rst = 1) = cycle 0: issue RESET_PC in cycle 0, entry visible with out_valid = 1 in cycle 2.
- Redirect in cycle t: first issue of redirect_pc in cycle t+1, out_valid with out_pc = redirect_pc in cycle t+3.
- Steady state with out_ready = 1: one instruction per cycle, consecutive PCs, no bubbles.
- out_ready = 0: queue fills to QUEUE_DEPTH, then imem_rd_en = 0; resumes the cycle after a pop drops count + inflight below QUEUE_DEPTH.
- Order preserved: out_pc strictly sequential except across redirect.

## Test plan
- Reset, fetch_en = 1, out_ready = 1, memory word = address: out_valid from cycle 2, out_pc = 0x20, 0x21, 0x22 ... with out_instr = out_pc, one per cycle.
- out_ready = 0 from cycle 0: queue_count saturates at 4, imem_rd_en = 0 afterward, imem_addr frozen at 0x24; raise out_ready -> pops 0x20..0x23, then 0x24 with no gap or duplicate.
- Redirect to 0x100 while queue holds 3 entries and a read is in flight: next cycle queue_count = 0, out_valid = 0; first out_pc = 0x100 three cycles after redirect; no stale PC ever appears.
- ADDR_WIDTH = 4, RESET_PC = 0xE: out_pc sequence 0xE, 0xF, 0x0, 0x1.
- fetch_en = 0 for 5 cycles mid-stream: in-flight word still queued, no issues, fetch_pc held; resume with next sequential PC.
- rst asserted mid-stream with redirect_valid = 1 same cycle: next cycle queue empty, imem_addr = 0x20 (redirect ignored), refetch from 0x20.
